spi_coord_master: RTL

- SPI mode-0 master that reads one 32-bit coordinate frame from the tracking-sensor SPI slave.
- The frame carries two 16-bit words, X first then Y, each MSB first.
- The block unpacks the frame into a 10-bit X and a 9-bit Y coordinate and flags bad padding.
- It sits on the motor-control side and feeds the tracking controller one coordinate pair per `start` request.

---
 rtl/spi_coord_master_if.sv | 52 +++++
 rtl/spi_coord_master.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/spi_coord_master_if.sv
// Bundle of handshake and SPI bus signals for spi_coord_master.
// Signals:
//   start     - request one coordinate frame (driven by the user side)
//   busy      - frame in progress, start is ignored while high
//   valid     - one-cycle pulse when xdata/ydata update
//   frame_err - one-cycle pulse with valid when padding bits were nonzero
//   xdata     - last received 10-bit X coordinate
//   ydata     - last received 9-bit Y coordinate
//   sclk      - SPI clock, idles low (mode 0)
//   mosi      - SPI master-out data
//   miso      - SPI master-in data from the sensor
//   cs        - SPI chip select, active low
// The master modport is the controller's view and the slave modport is
// the view of whatever sits on the other side: user logic plus sensor.
interface spi_coord_master_if;
   logic       start;
   logic       busy;
   logic       valid;
   logic       frame_err;
   logic [9:0] xdata;
   logic [8:0] ydata;
   logic       sclk;
   logic       mosi;
   logic       miso;
   logic       cs;

   modport master (
      input  start,
      input  miso,
      output busy,
      output valid,
      output frame_err,
      output xdata,
      output ydata,
      output sclk,
      output mosi,
      output cs
   );

   modport slave (
      output start,
      output miso,
      input  busy,
      input  valid,
      input  frame_err,
      input  xdata,
      input  ydata,
      input  sclk,
      input  mosi,
      input  cs
   );
endinterface

// File: rtl/spi_coord_master.sv
// SPI mode-0 master that reads one 32-bit coordinate frame per start request.
// The frame is X word then Y word, MSB first: {6'b0, x[9:0]}, {7'b0, y[8:0]}.
// It unpacks a 10-bit X and a 9-bit Y coordinate and flags nonzero padding.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset
//   bus   - spi_coord_master_if.master (start/busy/valid/frame_err/xdata/
//           ydata handshake plus the sclk/mosi/miso/cs SPI pins)
// Parameters:
//   CLK_DIV - SCLK half-period in clk cycles, must be at least 2
//   CMD     - command byte shifted out on MOSI during the first 8 bits
module spi_coord_master #(
   parameter int         CLK_DIV = 4,
   parameter logic [7:0] CMD     = 8'hA5
) (
   input logic                 clk,
   input logic                 reset,
   spi_coord_master_if.master  bus
);

   localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SETUP = 3'd1;
   localparam logic [2:0] XFER  = 3'd2;
   localparam logic [2:0] HOLD  = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;
   localparam logic [2:0] GAP   = 3'd5;

   logic [2:0]    state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [5:0]    hp_q, hp_d;
   logic [31:0]   sr_q, sr_d;
   logic          sclk_q, sclk_d;
   logic          mosi_q, mosi_d;
   logic          cs_q, cs_d;
   logic [9:0]    xdata_q, xdata_d;
   logic [8:0]    ydata_q, ydata_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;
   logic          busy_q, busy_d;

   logic          divEnd;
   logic [5:0]    nextBit;
   logic          nextMosi;

   // The divider wraps every CLK_DIV cycles; every state that waits a
   // half-period keys off this single terminal-count flag.
   assign divEnd = (div_q == DIV_LAST);

   // The half-period counter's upper five bits are the index of the bit on
   // the wire. After a falling edge the next bit goes out: command bits for
   // indices 0-7, zero afterwards (including past the last bit).
   assign nextBit  = {1'b0, hp_q[5:1]} + 6'd1;
   assign nextMosi = (nextBit < 6'd8) ? CMD[3'd7 - nextBit[2:0]] : 1'b0;

   // Next-state logic for the whole frame sequence. SCLK rises at the end
   // of each even half-period, which is also the clk edge that samples MISO,
   // and falls at the end of each odd one, which is when MOSI advances.
   // The DONE cycle counts as the first cycle of inter-frame quiet time, so
   // GAP starts with the divider already at one; that keeps the
   // start-to-start spacing at 67*CLK_DIV+1 cycles.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      hp_d    = hp_q;
      sr_d    = sr_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      cs_d    = cs_q;
      xdata_d = xdata_q;
      ydata_d = ydata_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      busy_d  = busy_q;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (bus.start) begin
               state_d = SETUP;
               cs_d    = 1'b0;
               busy_d  = 1'b1;
               mosi_d  = CMD[7];
               div_d   = '0;
               hp_d    = '0;
            end
         end
         SETUP: begin
            if (divEnd) begin
               state_d = XFER;
               div_d   = '0;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         XFER: begin
            if (divEnd) begin
               div_d = '0;
               hp_d  = hp_q + 6'd1;
               if (!hp_q[0]) begin
                  sclk_d = 1'b1;
                  sr_d   = {sr_q[30:0], bus.miso};
               end else begin
                  sclk_d = 1'b0;
                  mosi_d = nextMosi;
                  if (hp_q == 6'd63) begin
                     state_d = HOLD;
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         HOLD: begin
            if (divEnd) begin
               state_d = DONE;
               div_d   = '0;
               cs_d    = 1'b1;
               xdata_d = sr_q[25:16];
               ydata_d = sr_q[8:0];
               valid_d = 1'b1;
               err_d   = (|sr_q[31:26]) | (|sr_q[15:9]);
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         DONE: begin
            state_d = GAP;
            div_d   = DW'(1);
         end
         GAP: begin
            if (divEnd) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               div_d   = '0;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cs_d    = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State register. Reset drops any partial frame and releases chip
   // select immediately, without waiting for a clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         hp_q    <= '0;
         sr_q    <= '0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         cs_q    <= 1'b1;
         xdata_q <= '0;
         ydata_q <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         hp_q    <= hp_d;
         sr_q    <= sr_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         cs_q    <= cs_d;
         xdata_q <= xdata_d;
         ydata_q <= ydata_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   // All outputs come straight from registers so the SPI pins are glitch-free.
   assign bus.sclk      = sclk_q;
   assign bus.mosi      = mosi_q;
   assign bus.cs        = cs_q;
   assign bus.xdata     = xdata_q;
   assign bus.ydata     = ydata_q;
   assign bus.valid     = valid_q;
   assign bus.frame_err = err_q;
   assign bus.busy      = busy_q;

endmodule
